// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter in front of a shared immediate-extension datapath.
// Two requesters (0: ALU operand, 1: branch/jump target) compete for one
// extender; the result sits in a one-entry output register with valid/ready.
module imm_ext_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_imm0,
    input  logic [1:0]  req_mode0,
    input  logic [15:0] req_imm1,
    input  logic [1:0]  req_mode1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_id
);

    typedef enum logic [1:0] {
        ModeSign   = 2'b00,
        ModeZero   = 2'b01,
        ModeUpper  = 2'b10,
        ModeBranch = 2'b11
    } ext_mode_e;

    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        out_id_q;
    logic        last_grant_q;

    logic [1:0]  grant;
    logic        grant_idx;
    logic        can_accept;
    logic        accept;
    logic [15:0] sel_imm;
    logic [1:0]  sel_mode;
    logic [31:0] ext_data;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign grant_idx  = grant[1];
    // The output slot is free if empty or being drained this cycle.
    assign can_accept = !out_valid_q || out_ready;
    assign req_ready  = grant & {2{can_accept}};
    assign accept     = |req_ready;

    assign sel_imm  = grant_idx ? req_imm1  : req_imm0;
    assign sel_mode = grant_idx ? req_mode1 : req_mode0;

    // Extend the granted immediate according to its mode.
    always_comb begin
        ext_data = 32'h0;
        unique case (ext_mode_e'(sel_mode))
            ModeSign:   ext_data = {{16{sel_imm[15]}}, sel_imm};
            ModeZero:   ext_data = {16'h0, sel_imm};
            ModeUpper:  ext_data = {sel_imm, 16'h0};
            ModeBranch: ext_data = {{14{sel_imm[15]}}, sel_imm, 2'b00};
            default:    ext_data = 32'h0;
        endcase
    end

    // Output register and round-robin pointer; pointer moves only on an accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0;
            out_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= ext_data;
            out_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
        end else if (out_ready) begin
            // Drain without refill; data and id keep their last values.
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed testbench for imm_ext_arbiter. Inputs change just after the falling
// edge; req_ready is sampled before the rising edge, registers 1 time unit after it.
module tb_imm_ext_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_imm0;
    logic [1:0]  req_mode0;
    logic [15:0] req_imm1;
    logic [1:0]  req_mode1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_id;

    int pass_cnt  = 0;
    int total_cnt = 0;

    imm_ext_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_imm0  (req_imm0),
        .req_mode0 (req_mode0),
        .req_imm1  (req_imm1),
        .req_mode1 (req_mode1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b0;
        req_imm0  = 16'h0;
        req_mode0 = 2'b00;
        req_imm1  = 16'h0;
        req_mode1 = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_id !== 1'b0) $display("FAIL reset_id: got %b expected 0", out_id);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 2'b01;
        req_imm0  = 16'h8001;
        req_mode0 = 2'b00;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL single_ready: got %b expected 01", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'hFFFF8001)
            $display("FAIL single_data: got %h expected FFFF8001", out_data);
        else pass_cnt++;
        total_cnt++;
        if (out_id !== 1'b0) $display("FAIL single_id: got %b expected 0", out_id);
        else pass_cnt++;
    endtask

    task automatic test_modes();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'hFFFFFFFE;
        exp_tab[1] = 32'h0000FFFE;
        exp_tab[2] = 32'hFFFE0000;
        exp_tab[3] = 32'hFFFFFFF8;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            req_valid = 2'b10;
            req_imm1  = 16'hFFFE;
            req_mode1 = 2'(m);
            out_ready = 1'b1;
            #1;
            total_cnt++;
            if (req_ready !== 2'b10)
                $display("FAIL mode%0d_ready: got %b expected 10", m, req_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_data !== exp_tab[m])
                $display("FAIL mode%0d_data: got %h expected %h", m, out_data, exp_tab[m]);
            else pass_cnt++;
            total_cnt++;
            if (out_id !== 1'b1) $display("FAIL mode%0d_id: got %b expected 1", m, out_id);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_ready [4];
        logic [31:0] exp_data [4];
        exp_ready[0] = 2'b01; exp_data[0] = 32'h1;
        exp_ready[1] = 2'b10; exp_data[1] = 32'h2;
        exp_ready[2] = 2'b01; exp_data[2] = 32'h1;
        exp_ready[3] = 2'b10; exp_data[3] = 32'h2;
        @(negedge clk);
        req_valid = 2'b11;
        req_imm0  = 16'h0001;
        req_mode0 = 2'b01;
        req_imm1  = 16'h0002;
        req_mode1 = 2'b01;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (req_ready !== exp_ready[i])
                $display("FAIL b2b%0d_ready: got %b expected %b", i, req_ready, exp_ready[i]);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== exp_data[i])
                $display("FAIL b2b%0d_data: got %b/%h expected 1/%h",
                         i, out_valid, out_data, exp_data[i]);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        // Pending result is 2 from requester 1, so requester 0 is next.
        req_valid = 2'b11;
        req_imm0  = 16'h1234;
        req_mode0 = 2'b00;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (req_ready !== 2'b00)
                $display("FAIL stall%0d_ready: got %b expected 00", i, req_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== 32'h2 || out_id !== 1'b1)
                $display("FAIL stall%0d_hold: got %b/%h/%b expected 1/00000002/1",
                         i, out_valid, out_data, out_id);
            else pass_cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL release_ready: got %b expected 01", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'h00001234 || out_id !== 1'b0)
            $display("FAIL release_data: got %b/%h/%b expected 1/00001234/0",
                     out_valid, out_data, out_id);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // last_grant is 0 here; reset must restore it to 1.
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 2'b11;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 1'b0)
            $display("FAIL midrst_state: got %b/%h/%b expected 0/00000000/0",
                     out_valid, out_data, out_id);
        else pass_cnt++;
        @(negedge clk);
        reset     = 1'b0;
        req_imm0  = 16'h00AB;
        req_mode0 = 2'b01;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL midrst_tie: got %b expected 01", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'h000000AB || out_id !== 1'b0)
            $display("FAIL midrst_data: got %b/%h/%b expected 1/000000AB/0",
                     out_valid, out_data, out_id);
        else pass_cnt++;
    endtask

    task automatic test_consume();
        @(negedge clk);
        req_valid = 2'b00;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 32'h000000AB || out_id !== 1'b0)
            $display("FAIL consume: got %b/%h/%b expected 0/000000AB/0",
                     out_valid, out_data, out_id);
        else pass_cnt++;
    endtask

    task automatic test_branch_boundary();
        logic [15:0] imm_tab [2];
        logic [31:0] exp_tab [2];
        imm_tab[0] = 16'h7FFF; exp_tab[0] = 32'h0001FFFC;
        imm_tab[1] = 16'h8000; exp_tab[1] = 32'hFFFE0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_valid = 2'b01;
            req_imm0  = imm_tab[i];
            req_mode0 = 2'b11;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            total_cnt++;
            if (out_data !== exp_tab[i])
                $display("FAIL branch%0d: got %h expected %h", i, out_data, exp_tab[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_consume();
        test_branch_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
